sd_cmd_responder: RTL and testbench

Card-side responder for the SD CMD line. It lets the host controller be exercised in loopback without a physical card. It oversamples the host's sd_clk and CMD output in the msoc_clk domain, deframes and CRC-checks 48-bit commands, and hands each command to local logic. It then serialises the R1/R3/R7 (48-bit) or R2 (136-bit) response that local logic supplies back onto the CMD line, with SD-correct framing and CRC7.

---
 rtl/sd_cmd_responder.sv | 198 +++++++++++++++++++
 tb/tb_sd_cmd_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD responder: deframes host commands and serialises
// R1/R3/R7/R2 responses back onto CMD for controller loopback.
module sd_cmd_responder #(
    parameter int NCR          = 2,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic         msoc_clk,
    input  logic         rstn,
    input  logic         sd_clk,
    input  logic         sd_cmd_oe,
    input  logic         sd_cmd_to_mem,
    output logic         sd_cmd_to_host,
    output logic         sd_cmd_card_oe,
    output logic         cmd_valid,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    output logic         cmd_err,
    input  logic         resp_valid,
    input  logic [1:0]   resp_type,
    input  logic [31:0]  resp_arg,
    input  logic [119:0] resp_long,
    output logic         busy
);

    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam int FW = $clog2(NCR + 2);

    typedef enum logic [2:0] {IDLE, RX, CHECK, WAIT_RESP, GAP, TX} state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    function automatic logic [6:0] crc7_120(input logic [119:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 119; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    state_t         state;
    logic [1:0]     clk_s;
    logic [1:0]     oe_s;
    logic [1:0]     dat_s;
    logic           clk_d;
    logic           line;
    logic           rise_en;
    logic           fall_en;
    logic [47:0]    sr;
    logic [7:0]     cnt;
    logic [7:0]     cnt_inc;
    logic [7:0]     tx_len;
    logic [TW-1:0]  tcnt;
    logic [FW-1:0]  fcnt;
    logic [135:0]   tx_frame;
    logic [135:0]   frame_next;
    logic [39:0]    r48_body;
    logic           tx_bit;

    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            clk_s <= '0;
            oe_s  <= '0;
            dat_s <= '0;
            clk_d <= 1'b0;
        end else begin
            clk_s <= {clk_s[0], sd_clk};
            oe_s  <= {oe_s[0], sd_cmd_oe};
            dat_s <= {dat_s[0], sd_cmd_to_mem};
            clk_d <= clk_s[1];
        end
    end

    assign line           = oe_s[1] ? dat_s[1] : 1'b1;
    assign rise_en        = clk_s[1] & ~clk_d;
    assign fall_en        = ~clk_s[1] & clk_d;
    assign cnt_inc        = (cnt == 8'd136) ? cnt : cnt + 8'd1;
    assign busy           = (state != IDLE);
    assign sd_cmd_to_host = sd_cmd_card_oe ? tx_bit : line;

    // Frames are held MSB-aligned so TX always shifts out bit 135.
    always_comb begin
        r48_body   = {2'b00, cmd_index, resp_arg};
        frame_next = '1;
        unique case (resp_type)
            2'd1:    frame_next = {r48_body, crc7_40(r48_body), 1'b1, 88'd0};
            2'd2:    frame_next = {2'b00, 6'h3F, resp_long, crc7_120(resp_long), 1'b1};
            2'd3:    frame_next = {2'b00, 6'h3F, resp_arg, 7'h7F, 1'b1, 88'd0};
            default: frame_next = '1;
        endcase
    end

    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            sr             <= '0;
            cnt            <= '0;
            tx_len         <= '0;
            tcnt           <= '0;
            fcnt           <= '0;
            tx_frame       <= '0;
            tx_bit         <= 1'b1;
            sd_cmd_card_oe <= 1'b0;
            cmd_valid      <= 1'b0;
            cmd_err        <= 1'b0;
            cmd_index      <= '0;
            cmd_arg        <= '0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            if (fall_en && fcnt != FW'(NCR)) fcnt <= fcnt + 1'b1;
            if (sd_cmd_card_oe && oe_s[1]) begin
                sd_cmd_card_oe <= 1'b0;
                tx_bit         <= 1'b1;
                cmd_err        <= 1'b1;
                state          <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (rise_en && !line) begin
                            sr    <= {sr[46:0], line};
                            cnt   <= 8'd1;
                            state <= RX;
                        end
                    end
                    RX: begin
                        if (rise_en) begin
                            sr  <= {sr[46:0], line};
                            cnt <= cnt_inc;
                            if (cnt == 8'd47) begin
                                fcnt  <= '0;
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (sr[46] && sr[0] && sr[7:1] == crc7_40(sr[47:8])) begin
                            cmd_valid <= 1'b1;
                            cmd_index <= sr[45:40];
                            cmd_arg   <= sr[39:8];
                            tcnt      <= '0;
                            state     <= WAIT_RESP;
                        end else begin
                            cmd_err <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    WAIT_RESP: begin
                        if (resp_valid) begin
                            if (resp_type == 2'd0) begin
                                state <= IDLE;
                            end else begin
                                tx_frame <= frame_next;
                                tx_len   <= (resp_type == 2'd2) ? 8'd136 : 8'd48;
                                state    <= GAP;
                            end
                        end else if (rise_en) begin
                            if (tcnt == TW'(RESP_TIMEOUT - 1)) state <= IDLE;
                            else tcnt <= tcnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (fcnt == FW'(NCR)) state <= TX;
                    end
                    TX: begin
                        if (fall_en) begin
                            if (!sd_cmd_card_oe) begin
                                sd_cmd_card_oe <= 1'b1;
                                tx_bit         <= tx_frame[135];
                                tx_frame       <= {tx_frame[134:0], 1'b0};
                                cnt            <= 8'd1;
                            end else if (cnt == tx_len) begin
                                sd_cmd_card_oe <= 1'b0;
                                tx_bit         <= 1'b1;
                                state          <= IDLE;
                            end else begin
                                tx_bit   <= tx_frame[135];
                                tx_frame <= {tx_frame[134:0], 1'b0};
                                cnt      <= cnt_inc;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Randomised loopback bench for sd_cmd_responder: a bit-level host drives
// commands and a long-division CRC model predicts every frame.
module tb_sd_cmd_responder;

    localparam int NCR  = 2;
    localparam int SD_P = 80;

    logic         msoc_clk;
    logic         rstn;
    logic         sd_clk;
    logic         sd_cmd_oe;
    logic         sd_cmd_to_mem;
    logic         sd_cmd_to_host;
    logic         sd_cmd_card_oe;
    logic         cmd_valid;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic         cmd_err;
    logic         resp_valid;
    logic [1:0]   resp_type;
    logic [31:0]  resp_arg;
    logic [119:0] resp_long;
    logic         busy;

    int  pass_cnt = 0;
    int  chk_cnt  = 0;
    int  n_valid  = 0;
    int  n_err    = 0;
    int  n_oe     = 0;
    int  nv0;
    int  ne0;
    time t_end;

    sd_cmd_responder #(.NCR(NCR), .RESP_TIMEOUT(64)) dut (
        .msoc_clk       (msoc_clk),
        .rstn           (rstn),
        .sd_clk         (sd_clk),
        .sd_cmd_oe      (sd_cmd_oe),
        .sd_cmd_to_mem  (sd_cmd_to_mem),
        .sd_cmd_to_host (sd_cmd_to_host),
        .sd_cmd_card_oe (sd_cmd_card_oe),
        .cmd_valid      (cmd_valid),
        .cmd_index      (cmd_index),
        .cmd_arg        (cmd_arg),
        .cmd_err        (cmd_err),
        .resp_valid     (resp_valid),
        .resp_type      (resp_type),
        .resp_arg       (resp_arg),
        .resp_long      (resp_long),
        .busy           (busy)
    );

    initial begin
        msoc_clk = 1'b0;
        forever #5 msoc_clk = ~msoc_clk;
    end

    initial begin
        sd_clk = 1'b0;
        forever #(SD_P / 2) sd_clk = ~sd_clk;
    end

    always @(negedge msoc_clk) begin
        if (cmd_valid) n_valid++;
        if (cmd_err) n_err++;
        if (sd_cmd_card_oe) n_oe++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [6:0] ref_crc7(input logic [135:0] v, input int n);
        bit m[$];
        logic [7:0] poly;
        logic [6:0] r;
        poly = 8'h89;
        for (int i = n - 1; i >= 0; i--) m.push_back(v[i]);
        for (int i = 0; i < 7; i++) m.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (m[i]) for (int j = 0; j < 8; j++) m[i+j] = m[i+j] ^ poly[7-j];
        for (int i = 0; i < 7; i++) r[6-i] = m[n+i];
        return r;
    endfunction

    function automatic logic [47:0] model_cmd(input logic [5:0] idx, input logic [31:0] a);
        logic [39:0] body;
        body = {2'b01, idx, a};
        return {body, ref_crc7({96'd0, body}, 40), 1'b1};
    endfunction

    function automatic void model_resp(input logic [1:0] t, input logic [5:0] idx,
                                       input logic [31:0] a, input logic [119:0] l,
                                       output logic [135:0] f, output int n);
        n = 48;
        f = '0;
        if (t == 2'd1)
            f = {88'd0, 2'b00, idx, a, ref_crc7({96'd0, 2'b00, idx, a}, 40), 1'b1};
        else if (t == 2'd3)
            f = {88'd0, 2'b00, 6'h3F, a, 7'h7F, 1'b1};
        else if (t == 2'd2) begin
            n = 136;
            f = {2'b00, 6'h3F, l, ref_crc7({16'd0, l}, 120), 1'b1};
        end
    endfunction

    task automatic send_cmd(input logic [47:0] f);
        nv0 = n_valid;
        ne0 = n_err;
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk);
            sd_cmd_oe = 1'b1;
            sd_cmd_to_mem = f[i];
        end
        @(posedge sd_clk);
        t_end = $time;
        @(negedge sd_clk);
        sd_cmd_oe = 1'b0;
        sd_cmd_to_mem = 1'b1;
    endtask

    task automatic wait_cmd();
        for (int k = 0; k < 40; k++) begin
            if (n_valid != nv0 || n_err != ne0) break;
            @(negedge msoc_clk);
        end
    endtask

    task automatic pulse_resp(input logic [1:0] t, input logic [31:0] a, input logic [119:0] l);
        @(negedge msoc_clk);
        resp_valid = 1'b1;
        resp_type = t;
        resp_arg = a;
        resp_long = l;
        @(negedge msoc_clk);
        resp_valid = 1'b0;
    endtask

    task automatic get_resp(input int n, output logic [135:0] v, output int lat, output bit ok);
        ok = 1'b0;
        v = '0;
        lat = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge sd_clk);
            if (sd_cmd_to_host === 1'b0) begin
                ok = 1'b1;
                lat = int'(($time - t_end) / SD_P);
                break;
            end
        end
        if (ok)
            for (int i = 1; i < n; i++) begin
                @(posedge sd_clk);
                v = {v[134:0], sd_cmd_to_host};
            end
    endtask

    initial begin
        logic [135:0] got;
        logic [135:0] exp;
        logic [119:0] lng;
        logic [47:0]  f;
        logic [31:0]  a;
        logic [5:0]   idx;
        logic [1:0]   t;
        int           lat;
        int           n;
        int           oe0;
        bit           ok;
        bit           bad;

        rstn = 1'b0;
        sd_cmd_oe = 1'b0;
        sd_cmd_to_mem = 1'b1;
        resp_valid = 1'b0;
        resp_type = '0;
        resp_arg = '0;
        resp_long = '0;
        repeat (5) @(negedge msoc_clk);
        check("rst_host", sd_cmd_to_host, 1);
        check("rst_oe", sd_cmd_card_oe, 0);
        check("rst_pulses", {cmd_valid, cmd_err, busy}, 0);
        check("rst_cmd", {cmd_index, cmd_arg}, 0);
        rstn = 1'b1;
        repeat (3) @(posedge sd_clk);

        oe0 = n_oe;
        send_cmd(48'h400000000095);
        wait_cmd();
        check("cmd0_valid", n_valid - nv0, 1);
        check("cmd0_fields", {cmd_index, cmd_arg}, 0);
        pulse_resp(2'd0, '0, '0);
        repeat (4) @(posedge sd_clk);
        check("cmd0_busy", busy, 0);
        check("cmd0_nodrive", n_oe - oe0, 0);

        send_cmd(48'h48000001AA87);
        wait_cmd();
        check("cmd8_index", cmd_index, 8);
        pulse_resp(2'd1, 32'h000001AA, '0);
        get_resp(48, got, lat, ok);
        check("cmd8_start", ok, 1);
        check("cmd8_resp", got, 136'h08000001AA13);
        check("cmd8_ncr", lat >= NCR + 1, 1);
        repeat (2) @(posedge sd_clk);
        check("cmd8_release", {sd_cmd_card_oe, busy}, 0);

        oe0 = n_oe;
        send_cmd(48'h48000001AA86);
        wait_cmd();
        check("crc_err", n_err - ne0, 1);
        check("crc_noval", n_valid - nv0, 0);
        repeat (3) @(posedge sd_clk);
        check("crc_idle", {busy, n_oe - oe0}, 0);

        oe0 = n_oe;
        send_cmd(model_cmd(6'd55, 32'h0));
        repeat (63) @(posedge sd_clk);
        repeat (3) @(negedge msoc_clk);
        check("to_busy63", busy, 1);
        @(posedge sd_clk);
        repeat (3) @(negedge msoc_clk);
        check("to_busy64", busy, 0);
        pulse_resp(2'd1, 32'h1234, '0);
        repeat (4) @(posedge sd_clk);
        check("to_nodrive", n_oe - oe0, 0);

        a = $urandom;
        send_cmd(model_cmd(6'd55, 32'h0));
        repeat (64) @(posedge sd_clk);
        @(posedge msoc_clk);
        @(posedge msoc_clk);
        @(negedge msoc_clk);
        resp_valid = 1'b1;
        resp_type = 2'd1;
        resp_arg = a;
        @(negedge msoc_clk);
        resp_valid = 1'b0;
        model_resp(2'd1, 6'd55, a, '0, exp, n);
        get_resp(n, got, lat, ok);
        check("to_edge_start", ok, 1);
        check("to_edge_resp", got, exp);
        repeat (2) @(posedge sd_clk);

        send_cmd(model_cmd(6'd2, 32'h0));
        wait_cmd();
        pulse_resp(2'd2, '0, '0);
        get_resp(136, got, lat, ok);
        check("r2_zero", got, {2'b00, 6'h3F, 120'd0, 7'h00, 1'b1});
        repeat (2) @(posedge sd_clk);

        send_cmd(model_cmd(6'd41, 32'h0));
        wait_cmd();
        pulse_resp(2'd3, 32'h80FF8000, '0);
        get_resp(48, got, lat, ok);
        check("r3_resp", got, 136'h3F80FF8000FF);
        repeat (2) @(posedge sd_clk);

        for (int it = 0; it < 8; it++) begin
            idx = 6'($urandom_range(0, 63));
            a = $urandom;
            bad = ($urandom_range(0, 3) == 0);
            f = model_cmd(idx, a);
            if (bad) f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
            oe0 = n_oe;
            send_cmd(f);
            wait_cmd();
            if (bad) begin
                check("rnd_err", n_err - ne0, 1);
                check("rnd_noval", n_valid - nv0, 0);
                repeat (3) @(posedge sd_clk);
                check("rnd_err_idle", {busy, n_oe - oe0}, 0);
            end else begin
                check("rnd_valid", n_valid - nv0, 1);
                check("rnd_fields", {cmd_index, cmd_arg}, {idx, a});
                t = 2'($urandom_range(1, 3));
                lng = {$urandom, $urandom, $urandom, 24'($urandom)};
                a = $urandom;
                repeat ($urandom_range(0, 12)) @(negedge msoc_clk);
                pulse_resp(t, a, lng);
                model_resp(t, idx, a, lng, exp, n);
                get_resp(n, got, lat, ok);
                check("rnd_resp", got, exp);
                check("rnd_ncr", lat >= NCR + 1, 1);
                repeat (2) @(posedge sd_clk);
                check("rnd_idle", {busy, sd_cmd_card_oe}, 0);
            end
        end

        send_cmd(model_cmd(6'd8, 32'h1AA));
        wait_cmd();
        pulse_resp(2'd1, 32'h1AA, '0);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge sd_clk);
            if (sd_cmd_to_host === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_tx_start", ok, 1);
        repeat (20) @(posedge sd_clk);
        #3 rstn = 1'b0;
        #1;
        check("rst_tx_oe", sd_cmd_card_oe, 0);
        check("rst_tx_host", sd_cmd_to_host, 1);
        check("rst_tx_state", {busy, cmd_index}, 0);
        repeat (3) @(negedge msoc_clk);
        rstn = 1'b1;
        repeat (3) @(posedge sd_clk);
        send_cmd(48'h400000000095);
        wait_cmd();
        check("post_rst_valid", n_valid - nv0, 1);
        check("post_rst_fields", {cmd_index, cmd_arg}, 0);
        pulse_resp(2'd0, '0, '0);
        repeat (3) @(posedge sd_clk);
        check("post_rst_idle", {busy, sd_cmd_to_host}, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
